// File: rtl/func_ret_rob_pkg.sv
// Shared function-arbiter package: return-path widths and ROB types.
//   RET_DW     - return data width
//   CALL_SEQ_W - call sequence tag width
//   ROB_W      - reorder buffer depth (power of two, 1 << CALL_SEQ_W)
package func_ret_rob_pkg;

  localparam int unsigned RET_DW     = 32;
  localparam int unsigned CALL_SEQ_W = 2;
  localparam int unsigned ROB_W      = 1 << CALL_SEQ_W;

  typedef logic [CALL_SEQ_W-1:0] call_seq_t;

  typedef struct packed {
    logic              pend;
    logic              done;
    logic [RET_DW-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/func_ret_rob_if.sv
// Caller-side bundle of the return reorder buffer.
//   alloc_req/alloc_gnt/alloc_seq : call tag allocation
//   ret_valid/ret_seq/ret_data    : out-of-order return beats, ret_err flags bad beats
//   out_valid/out_data/out_ready  : in-order delivery to the caller
//   pend_cnt                      : allocated entries not yet popped
// slave modport is the buffer, master modport is the caller/arbiter side.
interface func_ret_rob_if
  import func_ret_rob_pkg::*;
#(
  parameter int unsigned RET_DW     = func_ret_rob_pkg::RET_DW,
  parameter int unsigned CALL_SEQ_W = func_ret_rob_pkg::CALL_SEQ_W
);
  logic                  alloc_req;
  logic                  alloc_gnt;
  logic [CALL_SEQ_W-1:0] alloc_seq;
  logic                  ret_valid;
  logic [CALL_SEQ_W-1:0] ret_seq;
  logic [RET_DW-1:0]     ret_data;
  logic                  ret_err;
  logic                  out_valid;
  logic [RET_DW-1:0]     out_data;
  logic                  out_ready;
  logic [CALL_SEQ_W:0]   pend_cnt;

  modport slave (
    input  alloc_req, ret_valid, ret_seq, ret_data, out_ready,
    output alloc_gnt, alloc_seq, ret_err, out_valid, out_data, pend_cnt
  );

  modport master (
    output alloc_req, ret_valid, ret_seq, ret_data, out_ready,
    input  alloc_gnt, alloc_seq, ret_err, out_valid, out_data, pend_cnt
  );
endinterface

// File: rtl/func_ret_rob.sv
// Per-caller return reorder buffer: hands out call tags in order, accepts
// returns in any order, and delivers them to the caller strictly in call order.
// Ports:
//   clk  - clock
//   rstn - synchronous active-low reset
//   bus  - func_ret_rob_if.slave (alloc, return and in-order output channels)
module func_ret_rob
  import func_ret_rob_pkg::*;
#(
  parameter int unsigned RET_DW     = func_ret_rob_pkg::RET_DW,
  parameter int unsigned CALL_SEQ_W = func_ret_rob_pkg::CALL_SEQ_W,
  parameter int unsigned ROB_W      = 1 << CALL_SEQ_W
) (
  input logic           clk,
  input logic           rstn,
  func_ret_rob_if.slave bus
);

  localparam int unsigned CNT_W = CALL_SEQ_W + 1;

  logic [CALL_SEQ_W-1:0] head;
  logic [CALL_SEQ_W-1:0] tail;
  logic [CNT_W-1:0]      count;
  logic [ROB_W-1:0]      pend;
  logic [ROB_W-1:0]      done;
  logic [RET_DW-1:0]     data [ROB_W];
  logic                  ret_err;

  logic alloc_fire_c;
  logic pop_c;
  logic ret_ok_c;

  // Grant is a pure function of the registered count: no pop-to-alloc bypass.
  assign bus.alloc_gnt = (count < CNT_W'(ROB_W));
  assign bus.alloc_seq = tail;
  assign bus.out_valid = done[head];
  assign bus.out_data  = data[head];
  assign bus.ret_err   = ret_err;
  assign bus.pend_cnt  = count;

  // Handshake qualifiers
  always_comb begin
    alloc_fire_c = bus.alloc_req && bus.alloc_gnt;
    pop_c        = done[head] && bus.out_ready;
    ret_ok_c     = pend[bus.ret_seq] && !done[bus.ret_seq];
  end

  // Pointers, counter and entry storage. Pop needs done=1 and a good return
  // needs done=0, so the two never touch the same entry in one cycle; alloc
  // only targets a non-pending tail entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pend    <= '0;
      done    <= '0;
      ret_err <= 1'b0;
      for (int unsigned i = 0; i < ROB_W; i++) begin
        data[i] <= '0;
      end
    end else begin
      ret_err <= bus.ret_valid && !ret_ok_c;

      if (alloc_fire_c) begin
        pend[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= tail + CALL_SEQ_W'(1);
      end

      if (bus.ret_valid && ret_ok_c) begin
        data[bus.ret_seq] <= bus.ret_data;
        done[bus.ret_seq] <= 1'b1;
      end

      if (pop_c) begin
        pend[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= head + CALL_SEQ_W'(1);
      end

      case ({alloc_fire_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_func_ret_rob.sv
// Directed self-checking bench for func_ret_rob.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_func_ret_rob;
  import func_ret_rob_pkg::*;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  func_ret_rob_if #(.RET_DW(RET_DW), .CALL_SEQ_W(CALL_SEQ_W)) bus ();

  func_ret_rob #(.RET_DW(RET_DW), .CALL_SEQ_W(CALL_SEQ_W), .ROB_W(ROB_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_req = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_seq   = '0;
    bus.ret_data  = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic ret_beat(input int seq, input logic [31:0] d);
    bus.ret_valid = 1'b1;
    bus.ret_seq   = call_seq_t'(seq);
    bus.ret_data  = RET_DW'(d);
    step();
    bus.ret_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   64'(bus.alloc_gnt), 64'd1);
    check({tag, "_seq"},   64'(bus.alloc_seq), 64'd0);
    check({tag, "_oval"},  64'(bus.out_valid), 64'd0);
    check({tag, "_odata"}, 64'(bus.out_data),  64'd0);
    check({tag, "_cnt"},   64'(bus.pend_cnt),  64'd0);
    check({tag, "_err"},   64'(bus.ret_err),   64'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    rstn = 1'b0;

    // Reset
    do_reset();
    check_reset_outputs("rst");

    // Fill: 5 requests, first 4 granted with tags 0..3
    for (int i = 0; i < 5; i++) begin
      bus.alloc_req = 1'b1;
      #0;
      check($sformatf("fill_gnt%0d", i), 64'(bus.alloc_gnt), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) check($sformatf("fill_seq%0d", i), 64'(bus.alloc_seq), 64'(i));
      step();
    end
    bus.alloc_req = 1'b0;
    check("fill_cnt", 64'(bus.pend_cnt), 64'd4);
    check("fill_gnt_full", 64'(bus.alloc_gnt), 64'd0);

    // Reorder: returns 2,0,3,1 with out_ready held high
    bus.out_ready = 1'b1;
    ret_beat(2, 32'hC);
    check("ro_wait_head", 64'(bus.out_valid), 64'd0);
    ret_beat(0, 32'hA);
    check("ro_a_valid", 64'(bus.out_valid), 64'd1);
    check("ro_a_data",  64'(bus.out_data),  64'hA);
    ret_beat(3, 32'hD);
    check("ro_stall", 64'(bus.out_valid), 64'd0);
    check("ro_stall_cnt", 64'(bus.pend_cnt), 64'd3);
    ret_beat(1, 32'hB);
    check("ro_b_valid", 64'(bus.out_valid), 64'd1);
    check("ro_b_data",  64'(bus.out_data),  64'hB);
    step();
    check("ro_c_valid", 64'(bus.out_valid), 64'd1);
    check("ro_c_data",  64'(bus.out_data),  64'hC);
    step();
    check("ro_d_valid", 64'(bus.out_valid), 64'd1);
    check("ro_d_data",  64'(bus.out_data),  64'hD);
    step();
    check("ro_empty", 64'(bus.out_valid), 64'd0);
    check("ro_cnt0",  64'(bus.pend_cnt),  64'd0);
    bus.out_ready = 1'b0;

    // Backpressure and full-pop (pointers have wrapped back to 0)
    bus.alloc_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.alloc_req = 1'b0;
    check("bp_cnt_full", 64'(bus.pend_cnt), 64'd4);
    ret_beat(0, 32'hA);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_hold_v%0d", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_hold_d%0d", i), 64'(bus.out_data),  64'hA);
      step();
    end
    bus.out_ready = 1'b1;
    bus.alloc_req = 1'b1;
    #0;
    check("fp_gnt_blocked", 64'(bus.alloc_gnt), 64'd0);
    step();
    bus.out_ready = 1'b0;
    check("fp_gnt_next", 64'(bus.alloc_gnt), 64'd1);
    check("fp_seq_next", 64'(bus.alloc_seq), 64'd0);
    check("fp_cnt_after_pop", 64'(bus.pend_cnt), 64'd3);
    step();
    bus.alloc_req = 1'b0;
    check("fp_cnt_refill", 64'(bus.pend_cnt), 64'd4);
    check("fp_gnt_full", 64'(bus.alloc_gnt), 64'd0);

    // Errors: unallocated tag 3 and duplicate return for tag 0
    do_reset();
    bus.alloc_req = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.alloc_req = 1'b0;
    ret_beat(0, 32'hA);
    check("err_none", 64'(bus.ret_err), 64'd0);
    ret_beat(3, 32'h33);
    check("err_unalloc", 64'(bus.ret_err), 64'd1);
    check("err_unalloc_cnt", 64'(bus.pend_cnt), 64'd3);
    step();
    check("err_unalloc_clr", 64'(bus.ret_err), 64'd0);
    ret_beat(0, 32'h55);
    check("err_dup", 64'(bus.ret_err), 64'd1);
    check("err_dup_data", 64'(bus.out_data), 64'hA);
    check("err_dup_cnt", 64'(bus.pend_cnt), 64'd3);
    step();
    check("err_dup_clr", 64'(bus.ret_err), 64'd0);
    // tag 3 must not have been marked done: popping 0,1,2 never exposes it
    bus.out_ready = 1'b1;
    step();
    check("err_t3_head1", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // Wrap: 7 rounds of alloc/return/pop
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.alloc_req = 1'b1;
      #0;
      check($sformatf("wr_seq%0d", i), 64'(bus.alloc_seq), 64'(i % 4));
      step();
      bus.alloc_req = 1'b0;
      ret_beat(i % 4, 32'h100 + 32'(i));
      bus.out_ready = 1'b1;
      check($sformatf("wr_v%0d", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("wr_d%0d", i), 64'(bus.out_data),  64'h100 + 64'(i));
      step();
      bus.out_ready = 1'b0;
    end
    check("wr_cnt0", 64'(bus.pend_cnt), 64'd0);
    check("wr_tail", 64'(bus.alloc_seq), 64'd3);

    // Reset with 2 calls pending, head one already done
    bus.alloc_req = 1'b1;
    step();
    step();
    bus.alloc_req = 1'b0;
    ret_beat(3, 32'h77);
    check("mr_pre_valid", 64'(bus.out_valid), 64'd1);
    check("mr_pre_cnt",   64'(bus.pend_cnt),  64'd2);
    rstn = 1'b0;
    step();
    check_reset_outputs("mr");
    rstn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
